// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer
//   pc_op_t    : decoder command encoding (5-7 behave as NOP)
//   pc_state_t : sequencer FSM states
//   VSEL_*     : vector select encodings
//   DEF_*      : default vector low-byte addresses
package pc_seq_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_INC    = 3'd1,
      OP_JMP    = 3'd2,
      OP_BRANCH = 3'd3,
      OP_VECTOR = 3'd4
   } pc_op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_JMP_LO,
      S_JMP_HI,
      S_BR_FIX,
      S_VEC_LO,
      S_VEC_HI
   } pc_state_t;

   localparam logic [1:0] VSEL_NMI = 2'b00;
   localparam logic [1:0] VSEL_RST = 2'b01;
   localparam logic [1:0] VSEL_IRQ = 2'b10;
   localparam logic [1:0] VSEL_BRK = 2'b11;

   localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
   localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;
   localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;

   // Both 10 and 11 select the IRQ/BRK vector.
   function automatic logic [15:0] vec_base(input logic [1:0] sel, input logic [15:0] nmi,
                                            input logic [15:0] rst, input logic [15:0] irq);
      return (sel == VSEL_NMI) ? nmi : (sel == VSEL_RST) ? rst : irq;
   endfunction

endpackage

// File: rtl/pc_branch_adder.sv
// pc_branch_adder: relative branch target computation
//   pc_i         : current program counter
//   offset_i     : signed 8-bit branch displacement
//   target_o     : pc_i + sign_extend(offset_i), modulo 2^16
//   page_cross_o : target lies in a different 256-byte page than pc_i
module pc_branch_adder (
   input  logic [15:0] pc_i,
   input  logic [7:0]  offset_i,
   output logic [15:0] target_o,
   output logic        page_cross_o
);

   assign target_o     = pc_i + {{8{offset_i[7]}}, offset_i};
   assign page_cross_o = target_o[15:8] != pc_i[15:8];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: 16-bit program counter sequencer (increment, jump, branch, vector fetch)
//   fclk, reset          : clock and synchronous active-high reset (reset starts a RESET_VECTOR fetch)
//   cmd_valid/cmd_op     : decoder command, accepted when cmd_ready (IDLE only)
//   vec_sel              : vector choice for OP_VECTOR
//   db_in/db_valid       : branch offset at accept, or fetched address bytes
//   pc_out               : current {PCH,PCL}
//   vec_addr/vec_req     : vector byte address being fetched
//   pch_carry            : pulse when PCL wraps or underflows
//   branch_penalty       : high in the page-cross fixup cycle
//   done                 : pulse when a command's PC update completes
// Optional feature: define PCSEQ_PAGE_PENALTY_EN for the two-cycle page-crossing branch.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [15:0] NMI_VECTOR   = DEF_NMI_VECTOR,
   parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR
) (
   input  logic        fclk,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd_op,
   input  logic [1:0]  vec_sel,
   output logic        cmd_ready,
   input  logic [7:0]  db_in,
   input  logic        db_valid,
   output logic [15:0] pc_out,
   output logic [15:0] vec_addr,
   output logic        vec_req,
   output logic        pch_carry,
   output logic        branch_penalty,
   output logic        done
);

   pc_state_t   state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] vec_addr_q, vec_addr_d;
   logic [7:0]  tmp_q, tmp_d;
   logic [7:0]  brh_q, brh_d;
   logic        carry_q, carry_d;
   logic        done_q, done_d;
   logic [15:0] target;
   logic        page_cross;

   pc_branch_adder u_adder (
      .pc_i         (pc_q),
      .offset_i     (db_in),
      .target_o     (target),
      .page_cross_o (page_cross)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      vec_addr_d = vec_addr_q;
      tmp_d      = tmp_q;
      brh_d      = brh_q;
      carry_d    = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_INC: begin
                     pc_d    = pc_q + 16'd1;
                     carry_d = &pc_q[7:0];
                     done_d  = 1'b1;
                  end
                  OP_JMP: state_d = S_JMP_LO;
                  OP_BRANCH: begin
                     carry_d = page_cross;
`ifdef PCSEQ_PAGE_PENALTY_EN
                     // Page cross: only PCL moves now; PCH is fixed up in BR_FIX.
                     if (page_cross) begin
                        pc_d    = {pc_q[15:8], target[7:0]};
                        brh_d   = target[15:8];
                        state_d = S_BR_FIX;
                     end else begin
                        pc_d   = target;
                        done_d = 1'b1;
                     end
`else
                     pc_d   = target;
                     done_d = 1'b1;
`endif
                  end
                  OP_VECTOR: begin
                     vec_addr_d = vec_base(vec_sel, NMI_VECTOR, RESET_VECTOR, IRQ_VECTOR);
                     state_d    = S_VEC_LO;
                  end
                  default: ;
               endcase
            end
         end
         S_JMP_LO: begin
            if (db_valid) begin
               tmp_d   = db_in;
               state_d = S_JMP_HI;
            end
         end
         S_BR_FIX: begin
            pc_d    = {brh_q, pc_q[7:0]};
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_VEC_LO: begin
            if (db_valid) begin
               tmp_d      = db_in;
               vec_addr_d = vec_addr_q + 16'd1;
               state_d    = S_VEC_HI;
            end
         end
         S_JMP_HI, S_VEC_HI: begin
            if (db_valid) begin
               pc_d    = {db_in, tmp_q};
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge fclk) begin
      if (reset) begin
         state_q    <= S_VEC_LO;
         pc_q       <= 16'h0000;
         vec_addr_q <= RESET_VECTOR;
         tmp_q      <= 8'h00;
         brh_q      <= 8'h00;
         carry_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         vec_addr_q <= vec_addr_d;
         tmp_q      <= tmp_d;
         brh_q      <= brh_d;
         carry_q    <= carry_d;
         done_q     <= done_d;
      end
   end

   assign cmd_ready = state_q == S_IDLE;
   assign vec_req   = (state_q == S_VEC_LO) || (state_q == S_VEC_HI);
   assign pc_out    = pc_q;
   assign vec_addr  = vec_addr_q;
   assign pch_carry = carry_q;
   assign done      = done_q;
`ifdef PCSEQ_PAGE_PENALTY_EN
   assign branch_penalty = state_q == S_BR_FIX;
`else
   assign branch_penalty = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        fclk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic [2:0]  cmd_op;
   logic [1:0]  vec_sel;
   logic        cmd_ready;
   logic [7:0]  db_in;
   logic        db_valid;
   logic [15:0] pc_out;
   logic [15:0] vec_addr;
   logic        vec_req;
   logic        pch_carry;
   logic        branch_penalty;
   logic        done;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .fclk           (fclk),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_op         (cmd_op),
      .vec_sel        (vec_sel),
      .cmd_ready      (cmd_ready),
      .db_in          (db_in),
      .db_valid       (db_valid),
      .pc_out         (pc_out),
      .vec_addr       (vec_addr),
      .vec_req        (vec_req),
      .pch_carry      (pch_carry),
      .branch_penalty (branch_penalty),
      .done           (done)
   );

   always #5 fclk = ~fclk;

   typedef struct {
      logic [15:0] start;
      logic [2:0]  op;
      logic [7:0]  db;
      logic [15:0] pc;
      logic        carry;
      logic        done;
   } vec_t;

   vec_t tbl[9];

   task automatic tick();
      @(posedge fclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic jmp(input logic [15:0] a);
      cmd_valid = 1'b1;
      cmd_op    = 3'd2;
      tick();
      cmd_valid = 1'b0;
      db_valid  = 1'b1;
      db_in     = a[7:0];
      tick();
      db_in = a[15:8];
      tick();
      db_valid = 1'b0;
      chk("jmp_setup_pc", pc_out, a);
   endtask

   initial begin
      tbl[0] = '{16'h12FF, 3'd1, 8'h00, 16'h1300, 1'b1, 1'b1};
      tbl[1] = '{16'hFFFF, 3'd1, 8'h00, 16'h0000, 1'b1, 1'b1};
      tbl[2] = '{16'h1234, 3'd1, 8'h00, 16'h1235, 1'b0, 1'b1};
      tbl[3] = '{16'hC010, 3'd3, 8'h05, 16'hC015, 1'b0, 1'b1};
      tbl[4] = '{16'hC080, 3'd3, 8'h80, 16'hC000, 1'b0, 1'b1};
      tbl[5] = '{16'hC0FF, 3'd3, 8'h00, 16'hC0FF, 1'b0, 1'b1};
      tbl[6] = '{16'hC020, 3'd3, 8'hF0, 16'hC010, 1'b0, 1'b1};
      tbl[7] = '{16'hC010, 3'd0, 8'h55, 16'hC010, 1'b0, 1'b0};
      tbl[8] = '{16'hC010, 3'd7, 8'h55, 16'hC010, 1'b0, 1'b0};

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; vec_sel = 2'b00;
      db_in = 8'h00; db_valid = 1'b0;
      tick();
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_vec_addr", vec_addr, 16'hFFFC);
      chk("rst_vec_req", vec_req, 1'b1);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_carry", pch_carry, 1'b0);
      chk("rst_penalty", branch_penalty, 1'b0);
      reset = 1'b0;
      tick();
      chk("rst_wait_vec_addr", vec_addr, 16'hFFFC);
      db_valid = 1'b1; db_in = 8'h00;
      tick();
      chk("rst_lo_vec_addr", vec_addr, 16'hFFFD);
      chk("rst_lo_vec_req", vec_req, 1'b1);
      chk("rst_lo_pc", pc_out, 16'h0000);
      db_in = 8'hC0;
      tick();
      db_valid = 1'b0;
      chk("rst_hi_pc", pc_out, 16'hC000);
      chk("rst_hi_done", done, 1'b1);
      chk("rst_hi_ready", cmd_ready, 1'b1);
      chk("rst_hi_vec_req", vec_req, 1'b0);
      chk("idle_vec_addr_hold", vec_addr, 16'hFFFD);
      db_valid = 1'b1; db_in = 8'hAA;
      tick();
      db_valid = 1'b0;
      chk("idle_db_ignored_pc", pc_out, 16'hC000);
      chk("idle_db_ignored_done", done, 1'b0);

      for (int i = 0; i < 9; i++) begin
         jmp(tbl[i].start);
         cmd_valid = 1'b1; cmd_op = tbl[i].op; db_in = tbl[i].db;
         tick();
         cmd_valid = 1'b0;
         chk($sformatf("tbl%0d_pc", i), pc_out, tbl[i].pc);
         chk($sformatf("tbl%0d_carry", i), pch_carry, tbl[i].carry);
         chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
         chk($sformatf("tbl%0d_ready", i), cmd_ready, 1'b1);
      end

      jmp(16'h00FE);
      cmd_valid = 1'b1; cmd_op = 3'd1;
      tick();
      chk("b2b_inc1_pc", pc_out, 16'h00FF);
      tick();
      cmd_valid = 1'b0;
      chk("b2b_inc2_pc", pc_out, 16'h0100);
      chk("b2b_inc2_carry", pch_carry, 1'b1);
      chk("b2b_inc2_done", done, 1'b1);

      jmp(16'hC0FE);
      cmd_valid = 1'b1; cmd_op = 3'd3; db_in = 8'h05;
      tick();
      cmd_valid = 1'b0;
      chk("px_fwd_c1_carry", pch_carry, 1'b1);
`ifdef PCSEQ_PAGE_PENALTY_EN
      chk("px_fwd_c1_pc", pc_out, 16'hC003);
      chk("px_fwd_c1_penalty", branch_penalty, 1'b1);
      chk("px_fwd_c1_done", done, 1'b0);
      chk("px_fwd_c1_ready", cmd_ready, 1'b0);
      tick();
      chk("px_fwd_c2_carry", pch_carry, 1'b0);
`endif
      chk("px_fwd_pc", pc_out, 16'hC103);
      chk("px_fwd_done", done, 1'b1);
      chk("px_fwd_penalty", branch_penalty, 1'b0);
      chk("px_fwd_ready", cmd_ready, 1'b1);

      jmp(16'hC002);
      cmd_valid = 1'b1; cmd_op = 3'd3; db_in = 8'hFA;
      tick();
      cmd_valid = 1'b0;
      chk("px_back_c1_carry", pch_carry, 1'b1);
`ifdef PCSEQ_PAGE_PENALTY_EN
      chk("px_back_c1_pc", pc_out, 16'hC0FC);
      chk("px_back_c1_penalty", branch_penalty, 1'b1);
      tick();
`endif
      chk("px_back_pc", pc_out, 16'hBFFC);
      chk("px_back_done", done, 1'b1);

      jmp(16'h5555);
      cmd_valid = 1'b1; cmd_op = 3'd2;
      tick();
      cmd_op = 3'd1;
      db_valid = 1'b1; db_in = 8'h34;
      tick();
      db_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("jmp_wait%0d_pc", i), pc_out, 16'h5555);
         chk($sformatf("jmp_wait%0d_ready", i), cmd_ready, 1'b0);
      end
      cmd_valid = 1'b0;
      db_valid = 1'b1; db_in = 8'h12;
      tick();
      db_valid = 1'b0;
      chk("jmp_pc", pc_out, 16'h1234);
      chk("jmp_done", done, 1'b1);
      tick();
      chk("jmp_done_pulse", done, 1'b0);

      cmd_valid = 1'b1; cmd_op = 3'd4; vec_sel = 2'b10;
      tick();
      cmd_valid = 1'b0;
      chk("irq_vec_addr", vec_addr, 16'hFFFE);
      chk("irq_vec_req", vec_req, 1'b1);
      db_valid = 1'b1; db_in = 8'h78;
      tick();
      chk("irq_lo_vec_addr", vec_addr, 16'hFFFF);
      db_in = 8'h56;
      tick();
      db_valid = 1'b0;
      chk("irq_pc", pc_out, 16'h5678);
      chk("irq_done", done, 1'b1);
      chk("irq_vec_req_off", vec_req, 1'b0);

      cmd_valid = 1'b1; cmd_op = 3'd4; vec_sel = 2'b11;
      tick();
      cmd_valid = 1'b0;
      chk("brk_vec_addr", vec_addr, 16'hFFFE);
      db_valid = 1'b1; db_in = 8'h01;
      tick();
      db_in = 8'h20;
      tick();
      db_valid = 1'b0;
      chk("brk_pc", pc_out, 16'h2001);

      cmd_valid = 1'b1; cmd_op = 3'd4; vec_sel = 2'b00;
      tick();
      cmd_valid = 1'b0;
      chk("nmi_vec_addr", vec_addr, 16'hFFFA);
      db_valid = 1'b1; db_in = 8'h11;
      tick();
      db_valid = 1'b0;
      chk("nmi_lo_vec_addr", vec_addr, 16'hFFFB);
      reset = 1'b1; db_valid = 1'b1; db_in = 8'h22;
      tick();
      reset = 1'b0; db_valid = 1'b0;
      chk("nmi_rst_pc", pc_out, 16'h0000);
      chk("nmi_rst_vec_addr", vec_addr, 16'hFFFC);
      chk("nmi_rst_vec_req", vec_req, 1'b1);
      chk("nmi_rst_done", done, 1'b0);
      db_valid = 1'b1; db_in = 8'h00;
      tick();
      db_in = 8'h80;
      tick();
      db_valid = 1'b0;
      chk("nmi_rst_refetch_pc", pc_out, 16'h8000);
      chk("nmi_rst_refetch_done", done, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controller that sequences the 16-bit program counter: low byte (PCL) and high byte (PCH) with carry between them.
- Executes increment, two-byte jump load, relative branch and interrupt/reset vector fetch requested by the instruction decoder.
- Presents the current PC to the address and data-bus muxes.
- Owns the PCL-to-PCH carry and the page-cross fixup cycle.

Parameters:
RESET_VECTOR, 16'hFFFC, address of reset vector low byte; high byte at RESET_VECTOR+1
NMI_VECTOR, 16'hFFFA, NMI vector low-byte address
IRQ_VECTOR, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
fclk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  decoder presents a command
cmd_op  in  3  pc_op_t: NOP=0, INC=1, JMP=2, BRANCH=3, VECTOR=4; 5-7 treated as NOP
vec_sel  in  2  for VECTOR: 00 NMI, 01 RST, 10 IRQ, 11 IRQ
cmd_ready  out  1  high only in IDLE
db_in  in  8  data bus: branch offset (sampled at accept) or address byte
db_valid  in  1  db_in holds a fetched address byte
pc_out  out  16  current PC {PCH,PCL}
vec_addr  out  16  vector byte address being fetched
vec_req  out  1  vector fetch in progress, vec_addr valid
pch_carry  out  1  one-cycle pulse when PCL wraps FF->00 or underflows 00->FF
branch_penalty  out  1  high during the page-cross fixup cycle
done  out  1  one-cycle pulse when a command's PC update completes

Behaviour:
- Reset (dominates everything, including mid-command):
  - Registered outputs: pc_out=16'h0000, pch_carry=0, branch_penalty=0, done=0.
  - Next state VEC_LO: vec_addr=RESET_VECTOR, vec_req=1, cmd_ready=0.
  - Any command in progress is abandoned.
- States: IDLE, JMP_LO, JMP_HI, BR_FIX, VEC_LO, VEC_HI.
- Accept condition is cmd_valid & cmd_ready. cmd_valid while not ready is ignored; the decoder holds it.
- NOP: no effect, no done.
- INC: pc_out<=pc_out+1 at the next edge, done=1 that cycle. Stays IDLE, so back-to-back INC is legal every cycle.
  - pch_carry=1 when PCL was FF.
  - FFFF wraps to 0000 with pch_carry=1.
- JMP: goes to JMP_LO.
  - JMP_LO: on db_valid, latch low byte into temp, go to JMP_HI.
  - JMP_HI: on db_valid, pc_out<={db_in,temp}, done=1, go to IDLE.
  - pc_out is unchanged until the high byte arrives.
- BRANCH: db_in is a signed 8-bit offset sampled at accept. target = pc_out + sign_extend(offset), modulo 2^16.
  - Same page (target[15:8]==pc_out[15:8]): pc_out<=target, done=1, stay IDLE. One cycle total.
  - Page cross:
    - Cycle 1: PCL<=target[7:0], pch_carry=1, go to BR_FIX.
    - BR_FIX: branch_penalty=1, PCH<=target[15:8], done=1, go to IDLE. Two cycles total.
- VECTOR: vec_addr=selected base, go to VEC_LO, vec_req=1.
  - VEC_LO: on db_valid, latch low byte; vec_addr=base+1; go to VEC_HI.
  - VEC_HI: on db_valid, pc_out<={db_in,temp}, done=1, vec_req=0, go to IDLE.
- db_valid outside JMP_LO, JMP_HI, VEC_LO and VEC_HI is ignored. Wait states are unbounded.
- In IDLE, vec_addr holds its last value and vec_req=0.
- Done after the post-reset vector fetch: done=1 pulses when VEC_HI completes.

Optional Feature:
PCSEQ_PAGE_PENALTY_EN
- Defined: page-crossing branches take the two-cycle BR_FIX path, matching 65C02 timing.
- Undefined: every branch completes in one cycle with the full 16-bit add. BR_FIX is unreachable, and branch_penalty is tied 0.
- pch_carry pulses on a page cross in both builds.

Decomposition:
- Package pc_seq_pkg:
  - pc_op_t enum (3 bits).
  - pc_state_t enum.
  - vector select encodings.
  - default vector address constants.
- One sub-module, pc_branch_adder: combinational. Inputs pc and offset; outputs target and page_cross. It isolates the sign-extension and cross detection for unit test.

Test Plan:
- Reset, then db_valid with 8'h00 followed by 8'hC0 → vec_addr FFFC then FFFD, vec_req high throughout; pc_out=C000, done pulse, cmd_ready=1.
- PC=12FF, INC → pc_out=1300, pch_carry=1, done=1. Then INC at FFFF → 0000 with pch_carry=1.
- PC=C010, BRANCH offset 8'h05 → C015 in 1 cycle. PC=C0FE, offset 8'h05 → cycle 1 PC=C003, then BR_FIX branch_penalty=1, PC=C103 (feature on); 1 cycle direct to C103 (feature off).
- PC=C002, BRANCH offset 8'hFA (-6) → PCL=FC with pch_carry, then PC=BFFC after BR_FIX.
- JMP with db bytes 34, 12 separated by 3 idle cycles with db_valid=0 → pc_out unchanged until the second byte, then 1234. cmd_valid held meanwhile is not accepted.
- VECTOR vec_sel=00 with reset asserted during VEC_HI → PC=0000 and vec_addr=FFFC next cycle, and the NMI load never completes.
